// File: rtl/isqrt_pkg.sv
// Shared definitions for the inverse-square-root feeder: FP32 field layout,
// operand class codes and the classifier used when ISQRT_FEEDER_CLASSIFY_EN is set.
package isqrt_pkg;

  localparam int unsigned F32_W  = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned CLS_W  = 3;

  localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;
  localparam logic [F32_W-1:0] ONE_F32      = 32'h3F80_0000;

  typedef enum logic [CLS_W-1:0] {
    CLS_NORMAL = 3'd0,
    CLS_ZERO   = 3'd1,
    CLS_NEG    = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4,
    CLS_DENORM = 3'd5
  } cls_e;

  // Priority: NaN, +Inf, negative non-zero (incl. -Inf, -denorm), zero, denorm.
  function automatic cls_e classify(input logic [F32_W-1:0] f);
    logic              sgn;
    logic [EXP_W-1:0]  ex;
    logic [FRAC_W-1:0] fr;
    sgn = f[F32_W-1];
    ex  = f[F32_W-2 -: EXP_W];
    fr  = f[FRAC_W-1:0];
    if (ex == EXP_ALL_ONES && fr != '0)      classify = CLS_NAN;
    else if (ex == EXP_ALL_ONES && !sgn)     classify = CLS_INF;
    else if (sgn && (ex != '0 || fr != '0))  classify = CLS_NEG;
    else if (ex == '0 && fr == '0)           classify = CLS_ZERO;
    else if (ex == '0)                       classify = CLS_DENORM;
    else                                     classify = CLS_NORMAL;
  endfunction

endpackage

// File: rtl/isqrt_fifo.sv
// Power-of-two circular FIFO with occupancy count and synchronous flush.
module isqrt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign level = cnt;

endmodule

// File: rtl/isqrt_feeder.sv
// Credit-gated operand feeder for an inverse-square-root core.
// Optional operand classification is enabled by defining ISQRT_FEEDER_CLASSIFY_EN.
module isqrt_feeder
  import isqrt_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CREDITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [31:0]            in_data,
  output logic                   in_ready,
  input  logic                   credit_ret,
  output logic                   core_valid,
  output logic [31:0]            core_data,
  output logic [2:0]             core_cls,
  output logic [$clog2(DEPTH):0] level,
  output logic                   cred_err
);

`ifdef ISQRT_FEEDER_CLASSIFY_EN
  localparam int unsigned EW = F32_W + CLS_W;
`else
  localparam int unsigned EW = F32_W;
`endif

  localparam logic [3:0] CRED_MAX = 4'(CREDITS);

  logic          full;
  logic          empty;
  logic          push;
  logic          issue;
  logic [3:0]    cred;
  logic [EW-1:0] wentry;
  logic [EW-1:0] rentry;
  logic [31:0]   issue_data;

  assign in_ready = !full;
  // A flush in the same cycle discards the incoming operand.
  assign push  = in_valid && in_ready && !flush;
  assign issue = !empty && (cred != '0) && !flush;

  isqrt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (issue),
    .wdata (wentry),
    .rdata (rentry),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cred     <= CRED_MAX;
      cred_err <= 1'b0;
    end else begin
      unique case ({issue, credit_ret})
        2'b10: cred <= cred - 1'b1;
        2'b01: begin
          if (cred == CRED_MAX) cred_err <= 1'b1;
          else                  cred     <= cred + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ISQRT_FEEDER_CLASSIFY_EN
  cls_e in_cls;
  cls_e rd_cls;

  assign in_cls     = classify(in_data);
  assign wentry     = {in_cls, in_data};
  assign rd_cls     = cls_e'(rentry[EW-1 -: CLS_W]);
  // Special operands are replaced by 1.0 so the core produces a benign result.
  assign issue_data = (rd_cls == CLS_NORMAL) ? rentry[31:0] : ONE_F32;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_valid <= 1'b0;
      core_data  <= '0;
      core_cls   <= '0;
    end else begin
      core_valid <= issue;
      if (issue) begin
        core_data <= issue_data;
        core_cls  <= rd_cls;
      end
    end
  end
`else
  assign wentry     = in_data;
  assign issue_data = rentry;
  assign core_cls   = '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_valid <= 1'b0;
      core_data  <= '0;
    end else begin
      core_valid <= issue;
      if (issue) core_data <= issue_data;
    end
  end
`endif

endmodule

// File: tb/tb_isqrt_feeder.sv
// Directed plus randomized bench for isqrt_feeder against a queue-based reference model.
module tb_isqrt_feeder;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CREDITS = 4;
  localparam int unsigned LW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = '0;
  logic          credit_ret = 1'b0;
  logic          in_ready;
  logic          core_valid;
  logic [31:0]   core_data;
  logic [2:0]    core_cls;
  logic [LW-1:0] level;
  logic          cred_err;

  isqrt_feeder #(
    .DEPTH   (DEPTH),
    .CREDITS (CREDITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .credit_ret (credit_ret),
    .core_valid (core_valid),
    .core_data  (core_data),
    .core_cls   (core_cls),
    .level      (level),
    .cred_err   (cred_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q[$];
  int          cred_m = CREDITS;
  bit          err_m = 1'b0;
  logic [31:0] specials [5] = '{32'h0000_0000, 32'hBF80_0000, 32'h7F80_0000,
                                32'h7FC0_0000, 32'h0000_0001};

  function automatic logic [2:0] ref_cls(input logic [31:0] f);
    logic       s = f[31];
    logic [7:0] e = f[30:23];
    logic       frac_nz = (f[22:0] != 23'd0);
    logic       mag_nz  = (f[30:0] != 31'd0);
    if (e == 8'hFF && frac_nz) return 3'd4;
    if (e == 8'hFF && !s)      return 3'd3;
    if (s && mag_nz)           return 3'd2;
    if (!mag_nz)               return 3'd1;
    if (e == 8'h00)            return 3'd5;
    return 3'd0;
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] f);
`ifdef ISQRT_FEEDER_CLASSIFY_EN
    return (ref_cls(f) != 3'd0) ? 32'h3F80_0000 : f;
`else
    return f;
`endif
  endfunction

  function automatic logic [2:0] exp_cls(input logic [31:0] f);
`ifdef ISQRT_FEEDER_CLASSIFY_EN
    return ref_cls(f);
`else
    return 3'd0 & f[2:0];
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_core_valid"}, 32'(core_valid), 32'd0);
    chk({tag, "_core_data"},  core_data,       32'd0);
    chk({tag, "_core_cls"},   32'(core_cls),   32'd0);
    chk({tag, "_level"},      32'(level),      32'd0);
    chk({tag, "_cred_err"},   32'(cred_err),   32'd0);
  endtask

  // One clock cycle: drive inputs, check pre-edge status, advance model, check registered outputs.
  task automatic cyc(input bit v, input logic [31:0] d, input bit cr, input bit fl);
    bit          issue;
    bit          acc;
    logic [31:0] head;
    in_valid = v; in_data = d; credit_ret = cr; flush = fl;
    #1;
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("level", 32'(level), 32'(q.size()));
    issue = (q.size() > 0) && (cred_m > 0) && !fl;
    acc   = v && (q.size() < DEPTH) && !fl;
    head  = issue ? q[0] : 32'd0;
    if (fl) q.delete();
    else begin
      if (issue) void'(q.pop_front());
      if (acc) q.push_back(d);
    end
    if (issue && !cr) cred_m--;
    else if (cr && !issue) begin
      if (cred_m == CREDITS) err_m = 1'b1;
      else cred_m++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; credit_ret = 1'b0; flush = 1'b0;
    chk("core_valid", 32'(core_valid), 32'(issue));
    if (issue) begin
      chk("core_data", core_data, exp_data(head));
      chk("core_cls", 32'(core_cls), 32'(exp_cls(head)));
    end
    chk("cred_err", 32'(cred_err), 32'(err_m));
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, (cred_m < CREDITS), 1'b0);
  endtask

  task automatic model_reset();
    q.delete();
    cred_m = CREDITS;
    err_m  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          v, cr, fl;
    logic [31:0] d;

    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b1;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    model_reset();

    // Single normal operand: visible two cycles after acceptance.
    cyc(1'b1, 32'h4080_0000, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("lat_valid", 32'(core_valid), 32'd1);
    chk("lat_data", core_data, 32'h4080_0000);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);

    // Five back-to-back with four credits: fifth is held until a credit returns.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h3F00_0000 + (32'(i) << 20), 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("held_level", 32'(level), 32'd1);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("fifth_issued", 32'(core_valid), 32'd1);
    settle(6);

    // Special operands.
    for (int i = 0; i < 5; i++) cyc(1'b1, specials[i], 1'b0, 1'b0);
    settle(10);

    // Exhaust credits, fill the FIFO, try a push on full, then flush with a concurrent push.
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h4100_0000 + 32'(i), 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < int'(DEPTH); i++) cyc(1'b1, 32'h4200_0000 + 32'(i), 1'b0, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_level", 32'(level), 32'(DEPTH));
    cyc(1'b1, 32'h4300_0000, 1'b0, 1'b0);
    cyc(1'b1, 32'h4400_0000, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    settle(6);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      v  = ($urandom_range(0, 2) != 0);
      d  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      cr = (cred_m < CREDITS) && ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 39) == 0);
      cyc(v, d, cr, fl);
    end
    settle(12);

    // Credit overflow sets a sticky error.
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 32'd0, 1'b0, 1'b0);

    // Asynchronous reset mid-stream.
    cyc(1'b1, 32'h4080_0000, 1'b0, 1'b0);
    cyc(1'b1, 32'h4110_0000, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h4120_0000;
    rst = 1'b0;
    #1;
    chk_reset("midrst");
    @(posedge clk); #1;
    chk_reset("midrst_hold");
    in_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (3) cyc(1'b0, 32'd0, 1'b0, 1'b0);
    cyc(1'b1, 32'h4040_0000, 1'b0, 1'b0);
    settle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
